// File: rtl/demux_frame_loader.sv
// demux_frame_loader: framed serial-to-parallel loader with a shadow bank filling
// behind a held output bank, both sides under valid/ready handshakes.
module demux_frame_loader #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 288,
    parameter int FCNT_W = 16,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sof,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         fill_idx,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic                     sof_err
);
    typedef enum logic {FILL, XFER} state_t;

    state_t                     state, state_n;
    logic [NUM_CH*DATA_W-1:0]   shadow;
    logic                       accept, last, free, load;

    always_comb begin
        state_n  = state;
        in_ready = (state == FILL);
        accept   = in_valid && in_ready;
        last     = (fill_idx == IDX_W'(NUM_CH - 1));
        free     = !out_valid || out_ready;
        load     = (state == XFER) && free;
        if (accept && !in_sof && last)
            state_n = XFER;
        if (load)
            state_n = FILL;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= FILL;
        else
            state <= state_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            fill_idx  <= '0;
            frame_cnt <= '0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= accept && in_sof && (fill_idx != '0);
            // an in_sof sample always restarts the frame at slot 0
            if (accept) begin
                if (in_sof) begin
                    shadow[DATA_W-1:0] <= in_data;
                    fill_idx           <= IDX_W'(1);
                end else begin
                    shadow[int'(fill_idx)*DATA_W +: DATA_W] <= in_data;
                    fill_idx <= last ? '0 : fill_idx + IDX_W'(1);
                end
            end
            if (load) begin
                out_data  <= shadow;
                out_valid <= 1'b1;
            end else if (out_ready)
                out_valid <= 1'b0;
            if (out_valid && out_ready)
                frame_cnt <= frame_cnt + FCNT_W'(1);
        end
endmodule

// File: tb/tb_demux_frame_loader.sv
// tb_demux_frame_loader: a 4-slot instance with a 2-bit frame counter for directed and
// random tests, plus a default 288x8 instance streaming counted frames.
module tb_demux_frame_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    logic        a_rst_n, a_in_valid, a_in_sof, a_in_ready, a_out_valid, a_out_ready, a_sof_err;
    logic [7:0]  a_in_data;
    logic [31:0] a_out_data;
    logic [1:0]  a_fill_idx, a_frame_cnt;

    demux_frame_loader #(.DATA_W(8), .NUM_CH(4), .FCNT_W(2)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_sof(a_in_sof), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .fill_idx(a_fill_idx),
        .frame_cnt(a_frame_cnt), .sof_err(a_sof_err)
    );

    logic          b_rst_n, b_in_valid, b_in_sof, b_in_ready, b_out_valid, b_out_ready, b_sof_err;
    logic [7:0]    b_in_data;
    logic [2303:0] b_out_data;
    logic [8:0]    b_fill_idx;
    logic [15:0]   b_frame_cnt;

    demux_frame_loader u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_sof(b_in_sof), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .fill_idx(b_fill_idx),
        .frame_cnt(b_frame_cnt), .sof_err(b_sof_err)
    );

    // reference model for the small instance: a list of accepted samples grouped into frames
    logic [7:0]  a_cur [4];
    int          a_cnt = 0;
    logic [31:0] a_exp [$];
    int          a_sof_exp = 0, a_sof_seen = 0, a_dlv = 0;
    logic        a_rand = 1'b0, a_rdy_cmd = 1'b1, a_hold_v = 1'b0;
    logic [31:0] a_hold_d;

    function automatic void a_model(input logic [7:0] d, input logic s);
        if (s) begin
            if (a_cnt != 0) a_sof_exp++;
            a_cur[0] = d;
            a_cnt = 1;
        end else begin
            a_cur[a_cnt] = d;
            a_cnt++;
            if (a_cnt == 4) begin
                a_exp.push_back({a_cur[3], a_cur[2], a_cur[1], a_cur[0]});
                a_cnt = 0;
            end
        end
    endfunction

    task automatic a_send(input logic [7:0] d, input logic s, input int gap);
        int n = 0;
        repeat (gap) begin @(negedge clk); a_in_valid = 1'b0; end
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_sof = s;
        while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
        if (a_in_ready) a_model(d, s);
        else begin chk("a_accept_timeout", a_in_ready, 1); a_in_valid = 1'b0; end
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin @(negedge clk); a_in_valid = 1'b0; a_in_sof = 1'b0; end
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_cnt = 0;
        @(negedge clk);
        a_rst_n = 1'b1;
    endtask

    task automatic a_drain();
        int n = 0;
        while (a_exp.size() != 0 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("a_drain", a_exp.size(), 0);
    endtask

    always begin
        @(negedge clk); #1;
        a_out_ready = a_rand ? 1'($urandom_range(1)) : a_rdy_cmd;
        if (a_sof_err) a_sof_seen++;
        if (!a_rst_n) begin
            a_hold_v = 1'b0; a_dlv = 0; a_exp.delete();
        end else begin
            if (a_hold_v) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_data", a_out_data, a_hold_d);
            end
            if (a_out_valid && a_out_ready) begin
                if (a_exp.size() == 0) chk("a_spurious_frame", a_out_valid, 0);
                else begin
                    chk("a_frame", a_out_data, a_exp.pop_front());
                    chk("a_frame_cnt", a_frame_cnt, a_dlv % 4);
                    a_dlv++;
                end
            end
            a_hold_v = a_out_valid && !a_out_ready;
            a_hold_d = a_out_data;
        end
    end

    // big instance: slot k of every frame carries k mod 256
    logic [2303:0] b_cur, b_e;
    logic [2303:0] b_exp [$];
    int            b_dlv = 0, b_sof_seen = 0;
    logic          b_done = 1'b0;

    initial begin
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_sof = 1'b0; b_cur = '0;
        repeat (3) @(negedge clk);
        b_rst_n = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 288; k++) begin
                int n = 0;
                int gap = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
                repeat (gap) begin @(negedge clk); b_in_valid = 1'b0; end
                @(negedge clk);
                b_in_valid = 1'b1; b_in_data = 8'(k); b_in_sof = (k == 0) && ($urandom_range(1) == 1);
                while (!b_in_ready && n < 1000) begin @(negedge clk); n++; end
                if (!b_in_ready) chk("b_accept_timeout", b_in_ready, 1);
                b_cur[k*8 +: 8] = 8'(k);
                if (k == 287) b_exp.push_back(b_cur);
            end
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int n = 0; n < 3000 && b_exp.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        chk("b_drain", b_exp.size(), 0);
        chk("b_frames_delivered", b_dlv, 3);
        chk("b_sof_err_pulses", b_sof_seen, 0);
        b_done = 1'b1;
    end

    always begin
        @(negedge clk); #1;
        b_out_ready = 1'($urandom_range(1));
        if (b_sof_err) b_sof_seen++;
        if (b_rst_n && b_out_valid && b_out_ready) begin
            if (b_exp.size() == 0) chk("b_spurious_frame", b_out_valid, 0);
            else begin
                b_e = b_exp.pop_front();
                total++;
                if (b_out_data === b_e) passed++;
                else
                    for (int k = 0; k < 288; k++)
                        if (b_out_data[k*8 +: 8] !== b_e[k*8 +: 8]) begin
                            $display("FAIL b_frame slot %0d: got %0h, expected %0h", k, b_out_data[k*8 +: 8], b_e[k*8 +: 8]);
                            break;
                        end
                chk("b_frame_cnt", b_frame_cnt, 16'(b_dlv));
                b_dlv++;
            end
        end
    end

    initial begin
        int n;
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_sof = 1'b0;
        @(negedge clk); #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_fill_idx", a_fill_idx, 0);
        chk("rst_frame_cnt", a_frame_cnt, 0);
        chk("rst_sof_err", a_sof_err, 0);
        chk("rst_in_ready", a_in_ready, 1);
        @(negedge clk);
        a_rst_n = 1'b1;

        a_send(8'h11, 0, 0); a_send(8'h22, 0, 0); a_send(8'h33, 0, 0); a_send(8'h44, 0, 0);
        @(negedge clk); a_in_valid = 1'b0;
        chk("lat_in_ready_low", a_in_ready, 0);
        chk("lat_out_valid_early", a_out_valid, 0);
        @(negedge clk);
        chk("lat_in_ready_back", a_in_ready, 1);
        chk("lat_out_valid", a_out_valid, 1);
        chk("lat_out_data", a_out_data, 32'h44332211);
        @(negedge clk);
        chk("lat_frame_cnt", a_frame_cnt, 1);
        chk("lat_out_valid_clear", a_out_valid, 0);

        a_reset();
        a_rdy_cmd = 1'b0;
        for (int i = 1; i <= 8; i++) a_send(8'(i), 0, 0);
        a_idle(3);
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_fill_idx", a_fill_idx, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_held_a", a_out_data, 32'h04030201);
        a_rdy_cmd = 1'b1;
        @(negedge clk);
        a_rdy_cmd = 1'b0;
        chk("bp_out_valid_kept", a_out_valid, 1);
        chk("bp_frame_b", a_out_data, 32'h08070605);
        chk("bp_frame_cnt", a_frame_cnt, 1);
        chk("bp_in_ready_back", a_in_ready, 1);
        a_rdy_cmd = 1'b1;
        a_idle(2);
        chk("bp_drain", a_exp.size(), 0);

        a_reset();
        a_send(8'hAA, 1, 0); a_send(8'hBB, 0, 0); a_send(8'hC1, 1, 0);
        a_send(8'hC2, 0, 0); a_send(8'hC3, 0, 0); a_send(8'hC4, 0, 0);
        a_idle(4);
        chk("sof_pulses", a_sof_seen, a_sof_exp);
        chk("sof_drain", a_exp.size(), 0);

        a_reset();
        for (int i = 1; i <= 4; i++) a_send(8'(i), 0, 0);
        a_idle(3);
        a_rdy_cmd = 1'b0;
        for (int i = 5; i <= 10; i++) a_send(8'(i), 0, 0);
        @(negedge clk); a_in_valid = 1'b0;
        chk("mid_fill_idx", a_fill_idx, 2);
        chk("mid_out_valid", a_out_valid, 1);
        chk("mid_frame_cnt", a_frame_cnt, 1);
        a_rst_n = 1'b0; a_cnt = 0;
        #1;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_out_data", a_out_data, 0);
        chk("mid_rst_fill_idx", a_fill_idx, 0);
        chk("mid_rst_frame_cnt", a_frame_cnt, 0);
        @(negedge clk);
        a_rst_n = 1'b1; a_rdy_cmd = 1'b1;
        for (int i = 0; i < 4; i++) a_send(8'(8'h21 + i), 0, 0);
        a_idle(3);
        chk("mid_clean_frame", a_exp.size(), 0);

        a_reset();
        a_rand = 1'b1;
        for (int f = 0; f < 5; f++)
            for (int k = 0; k < 4; k++)
                a_send(8'($urandom), (k == 0) && ($urandom_range(1) == 1), int'($urandom_range(2)));
        a_idle(1);
        a_drain();
        chk("wrap_frames", a_dlv, 5);
        chk("wrap_frame_cnt", a_frame_cnt, 1);

        for (int i = 0; i < 40; i++)
            a_send(8'($urandom), $urandom_range(5) == 0, int'($urandom_range(2)));
        a_idle(1);
        a_drain();
        chk("rand_sof_pulses", a_sof_seen, a_sof_exp);
        a_rand = 1'b0;

        n = 0;
        while (!b_done && n < 20000) begin @(negedge clk); n++; end
        if (!b_done) chk("b_done_timeout", b_done, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
